// File: rtl/serial_tx_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_tx_ctrl_if
//  Description : Bundles the transmit request/status and port-4 strobe
//                signals exchanged with the serial transmit sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_tx_ctrl_if;
    logic start;
    logic serial_in;
    logic Lo4;
    logic Sr;
    logic tx_line;
    logic busy;
    logic done;

    modport master (
        output start,
        output serial_in,
        input  Lo4,
        input  Sr,
        input  tx_line,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  serial_in,
        output Lo4,
        output Sr,
        output tx_line,
        output busy,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/serial_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_tx_ctrl
//  Description : Port-4 serial transmit sequencer: loads the port register,
//                paces shift strobes at BAUD_DIV cycles per bit and drives
//                the serial line. Define SERIAL_FRAME_EN for start/stop bits.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_tx_ctrl #(
    parameter int BAUD_DIV = 4,
    parameter int NBITS    = 8
) (
    input  wire logic         CLK,
    input  wire logic         CLR,
    serial_tx_ctrl_if.slave   bus
);

    localparam int c_BCNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int c_NBIT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [c_BCNT_W-1:0] c_BMAX = c_BCNT_W'(BAUD_DIV - 1);
    localparam logic [c_NBIT_W-1:0] c_NMAX = c_NBIT_W'(NBITS - 1);
    localparam logic [c_BCNT_W-1:0] c_BONE = c_BCNT_W'(1);
    localparam logic [c_NBIT_W-1:0] c_NONE = c_NBIT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
`ifdef SERIAL_FRAME_EN
        S_START = 3'd2,
        S_STOP  = 3'd4,
`endif
        S_DATA  = 3'd3,
        S_DONE  = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_BCNT_W-1:0]   r_bcnt;
    logic [c_BCNT_W-1:0]   w_bcnt_nxt;
    logic [c_NBIT_W-1:0]   r_nbit;
    logic [c_NBIT_W-1:0]   w_nbit_nxt;

    logic w_bwrap;
    logic w_last_bit;
    logic w_lo4;
    logic w_sr;
    logic w_tx;
    logic w_busy;
    logic w_done;

    assign w_bwrap    = (r_bcnt == c_BMAX);
    assign w_last_bit = (r_nbit == c_NMAX);

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state <= S_IDLE;
            r_bcnt  <= '0;
            r_nbit  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_nbit  <= w_nbit_nxt;
        end
    end

    // Outputs decode from registered state only, so CLR forces them at once.
    always_comb begin
        w_state_nxt = r_state;
        w_bcnt_nxt  = r_bcnt;
        w_nbit_nxt  = r_nbit;
        w_lo4       = 1'b0;
        w_sr        = 1'b0;
        w_tx        = 1'b1;
        w_busy      = 1'b1;
        w_done      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_state_nxt = S_LOAD;
                end
            end

            S_LOAD: begin
                w_lo4      = 1'b1;
                w_bcnt_nxt = '0;
                w_nbit_nxt = '0;
`ifdef SERIAL_FRAME_EN
                w_state_nxt = S_START;
`else
                w_state_nxt = S_DATA;
`endif
            end

`ifdef SERIAL_FRAME_EN
            S_START: begin
                w_tx       = 1'b0;
                w_bcnt_nxt = w_bwrap ? '0 : r_bcnt + c_BONE;
                if (w_bwrap) begin
                    w_state_nxt = S_DATA;
                end
            end

            S_STOP: begin
                w_bcnt_nxt = w_bwrap ? '0 : r_bcnt + c_BONE;
                if (w_bwrap) begin
                    w_state_nxt = S_DONE;
                end
            end
`endif

            S_DATA: begin
                w_tx       = bus.serial_in;
                w_bcnt_nxt = w_bwrap ? '0 : r_bcnt + c_BONE;
                // The last bit is already on serial_in, so it needs no shift.
                if (w_bwrap) begin
                    if (!w_last_bit) begin
                        w_sr       = 1'b1;
                        w_nbit_nxt = r_nbit + c_NONE;
                    end else begin
                        w_nbit_nxt = '0;
`ifdef SERIAL_FRAME_EN
                        w_state_nxt = S_STOP;
`else
                        w_state_nxt = S_DONE;
`endif
                    end
                end
            end

            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_busy      = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.Lo4     = w_lo4;
    assign bus.Sr      = w_sr;
    assign bus.tx_line = w_tx;
    assign bus.busy    = w_busy;
    assign bus.done    = w_done;

endmodule
`default_nettype wire
